// File: rtl/rv_clint.sv
// rv_clint: core-local interruptor (msip, 64-bit mtime, mtimecmp) for a single RV32 hart.
// Optional mtime prescaler is compiled in by defining CLINT_PRESCALE_EN.
module rv_clint #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [63:0] MTIME_RST = 64'h0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              bstart,
  input  logic              ttype,
  input  logic [1:0]        tsize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              irq_sw,
  output logic              irq_timer
);

  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] OFF_MSIP     = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] OFF_CMP_LO   = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] OFF_CMP_HI   = ADDR_W'(16'h4004);
  localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'(16'hBFF8);
  localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'(16'hBFFC);

  if (PRESCALE == 0) begin : g_bad_prescale
    $error("rv_clint: PRESCALE must be at least 1");
  end

  logic              msip;
  logic [63:0]       mtime;
  logic [63:0]       mtime_nxt;
  logic [63:0]       mtimecmp;
  logic [ADDR_W-1:0] addr_word;
  logic [3:0]        be;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] rd_word;
  logic              acc;
  logic              wr;
  logic              rd;
  logic              sel_msip;
  logic              sel_cmp_lo;
  logic              sel_cmp_hi;
  logic              sel_mtime_lo;
  logic              sel_mtime_hi;
  logic              tick;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [DATA_W-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign acc          = ss && bstart;
  assign wr           = acc && ttype;
  assign rd           = acc && !ttype;
  assign addr_word    = {addr[ADDR_W-1:2], 2'b00};
  assign sel_msip     = (addr_word == OFF_MSIP);
  assign sel_cmp_lo   = (addr_word == OFF_CMP_LO);
  assign sel_cmp_hi   = (addr_word == OFF_CMP_HI);
  assign sel_mtime_lo = (addr_word == OFF_MTIME_LO);
  assign sel_mtime_hi = (addr_word == OFF_MTIME_HI);
  assign irq_sw       = msip;

  // Byte-lane strobes; misaligned or reserved sizes fall back to a full word.
  always_comb begin
    be = 4'b1111;
    case (tsize)
      2'd0:    be = 4'b0001 << addr[1:0];
      2'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_comb begin
    rd_word = '0;
    if (sel_msip)     rd_word = {31'd0, msip};
    if (sel_cmp_lo)   rd_word = mtimecmp[31:0];
    if (sel_cmp_hi)   rd_word = mtimecmp[63:32];
    if (sel_mtime_lo) rd_word = mtime[31:0];
    if (sel_mtime_hi) rd_word = mtime[63:32];
  end

  // A low-word write freezes the whole counter for that edge; a high-word write drops the carry.
  always_comb begin
    mtime_nxt = tick ? (mtime + 64'd1) : mtime;
    if (wr && sel_mtime_lo) begin
      mtime_nxt = {mtime[63:32], merge_lanes(mtime[31:0], wdata, lane_mask)};
    end else if (wr && sel_mtime_hi) begin
      mtime_nxt = {merge_lanes(mtime[63:32], wdata, lane_mask),
                   tick ? (mtime[31:0] + 32'd1) : mtime[31:0]};
    end
  end

`ifdef CLINT_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] ps_cnt;
  logic            mtime_wr;

  assign mtime_wr = wr && (sel_mtime_lo || sel_mtime_hi);
  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || mtime_wr) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      msip      <= 1'b0;
      mtime     <= MTIME_RST;
      mtimecmp  <= '1;
      rdata     <= '0;
      done      <= 1'b0;
      irq_timer <= 1'b0;
    end else begin
      done      <= acc;
      mtime     <= mtime_nxt;
      irq_timer <= (mtime >= mtimecmp);
      if (rd) rdata <= rd_word;
      if (wr && sel_msip && be[0]) msip <= wdata[0];
      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0], wdata, lane_mask);
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wdata, lane_mask);
    end
  end

endmodule

// File: tb/tb_rv_clint.sv
// Directed self-checking bench for rv_clint (default build, prescaler disabled).
module tb_rv_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        bstart;
  logic        ttype;
  logic [1:0]  tsize;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        irq_sw;
  logic        irq_timer;

  int passed = 0;
  int total  = 0;

  rv_clint #(.ADDR_W(16), .MTIME_RST(64'h0), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .ss(ss), .bstart(bstart), .ttype(ttype), .tsize(tsize),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .irq_sw(irq_sw),
    .irq_timer(irq_timer)
  );

  always #5 clk = ~clk;

  // Issue one transfer from a negedge; returns at the next negedge (the done cycle).
  task automatic xfer(input logic tt, input logic [1:0] ts, input logic [15:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic dn);
    ss = 1'b1; bstart = 1'b1; ttype = tt; tsize = ts; addr = a; wdata = wd;
    @(negedge clk);
    ss = 1'b0; bstart = 1'b0;
    rd = rdata; dn = done;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic dn;
    rst = 1'b1; ss = 1'b0; bstart = 1'b0; ttype = 1'b0; tsize = 2'd0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 00000000", rdata); else passed++;
    total++; if (irq_sw !== 1'b0) $display("FAIL rst_irq_sw: got %b expected 0", irq_sw); else passed++;
    total++; if (irq_timer !== 1'b0) $display("FAIL rst_irq_timer: got %b expected 0", irq_timer); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
      total++; if (dn !== 1'b1) $display("FAIL mtime_read_done%0d: got %b expected 1", i, dn); else passed++;
      total++; if (rd !== 32'(i)) $display("FAIL mtime_read%0d: got %h expected %h", i, rd, 32'(i)); else passed++;
    end
    xfer(1'b0, 2'd2, 16'h4000, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_lo: got %h expected ffffffff", rd); else passed++;
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_hi: got %h expected ffffffff", rd); else passed++;
    total++; if (irq_timer !== 1'b0) $display("FAIL rst_irq_timer_run: got %b expected 0", irq_timer); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else passed++;
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic dn;
    total++; if (irq_sw !== 1'b0) $display("FAIL msip_pre: got %b expected 0", irq_sw); else passed++;
    xfer(1'b1, 2'd2, 16'h0000, 32'h1, rd, dn);
    total++; if (irq_sw !== 1'b1) $display("FAIL msip_set_irq: got %b expected 1", irq_sw); else passed++;
    xfer(1'b0, 2'd2, 16'h0000, 32'h0, rd, dn);
    total++; if (rd !== 32'h1) $display("FAIL msip_read1: got %h expected 00000001", rd); else passed++;
    xfer(1'b1, 2'd2, 16'h0000, 32'hFFFF_FFFE, rd, dn);
    total++; if (irq_sw !== 1'b0) $display("FAIL msip_clr_irq: got %b expected 0", irq_sw); else passed++;
    xfer(1'b0, 2'd2, 16'h0000, 32'h0, rd, dn);
    total++; if (rd !== 32'h0) $display("FAIL msip_read0: got %h expected 00000000", rd); else passed++;
    xfer(1'b1, 2'd2, 16'h0000, 32'hFFFF_FFFF, rd, dn);
    xfer(1'b0, 2'd2, 16'h0000, 32'h0, rd, dn);
    total++; if (rd !== 32'h1) $display("FAIL msip_upper_zero: got %h expected 00000001", rd); else passed++;
    xfer(1'b1, 2'd2, 16'h0000, 32'h0, rd, dn);
  endtask

  task automatic test_timer();
    logic [31:0] rd; logic [31:0] m; logic dn;
    xfer(1'b1, 2'd2, 16'h4004, 32'h0, rd, dn);
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, m, dn);
    xfer(1'b1, 2'd2, 16'h4000, m + 32'd20, rd, dn);
    total++; if (irq_timer !== 1'b0) $display("FAIL timer_early: got %b expected 0", irq_timer); else passed++;
    repeat (18) @(negedge clk);
    total++; if (irq_timer !== 1'b0) $display("FAIL timer_at_match: got %b expected 0", irq_timer); else passed++;
    @(negedge clk);
    total++; if (irq_timer !== 1'b1) $display("FAIL timer_rise: got %b expected 1", irq_timer); else passed++;
    xfer(1'b1, 2'd2, 16'h4000, 32'hFFFF_FFFF, rd, dn);
    total++; if (irq_timer !== 1'b1) $display("FAIL timer_hold: got %b expected 1", irq_timer); else passed++;
    @(negedge clk);
    total++; if (irq_timer !== 1'b0) $display("FAIL timer_fall: got %b expected 0", irq_timer); else passed++;
  endtask

  task automatic test_mtime_write();
    logic [31:0] rd; logic dn;
    xfer(1'b1, 2'd2, 16'hBFF8, 32'hFFFF_FFFE, rd, dn);
    xfer(1'b1, 2'd2, 16'hBFFC, 32'h0, rd, dn);
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL carry_lo_pre: got %h expected ffffffff", rd); else passed++;
    xfer(1'b0, 2'd2, 16'hBFFC, 32'h0, rd, dn);
    total++; if (rd !== 32'h1) $display("FAIL carry_hi: got %h expected 00000001", rd); else passed++;
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
    total++; if (rd !== 32'h1) $display("FAIL carry_lo_post: got %h expected 00000001", rd); else passed++;
    xfer(1'b1, 2'd2, 16'hBFF8, 32'hFFFF_FFFF, rd, dn);
    xfer(1'b1, 2'd2, 16'hBFFC, 32'h5, rd, dn);
    xfer(1'b0, 2'd2, 16'hBFFC, 32'h0, rd, dn);
    total++; if (rd !== 32'h5) $display("FAIL hi_write_drops_carry: got %h expected 00000005", rd); else passed++;
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
    total++; if (rd !== 32'h1) $display("FAIL hi_write_lo_inc: got %h expected 00000001", rd); else passed++;
    xfer(1'b1, 2'd2, 16'hBFF8, 32'h0000_0100, rd, dn);
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
    total++; if (rd !== 32'h100) $display("FAIL lo_write_no_inc: got %h expected 00000100", rd); else passed++;
    xfer(1'b0, 2'd2, 16'hBFFC, 32'h0, rd, dn);
    total++; if (rd !== 32'h5) $display("FAIL lo_write_hi_keep: got %h expected 00000005", rd); else passed++;
    xfer(1'b1, 2'd0, 16'hBFF9, 32'h0000_7700, rd, dn);
    xfer(1'b0, 2'd2, 16'hBFF8, 32'h0, rd, dn);
    total++; if (rd !== 32'h7702) $display("FAIL lo_byte_write: got %h expected 00007702", rd); else passed++;
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic dn;
    xfer(1'b1, 2'd2, 16'h4000, 32'hFFFF_FFFF, rd, dn);
    xfer(1'b1, 2'd2, 16'h4004, 32'hFFFF_FFFF, rd, dn);
    xfer(1'b1, 2'd0, 16'h4005, 32'h5555_AB55, rd, dn);
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_ABFF) $display("FAIL byte_lane1: got %h expected ffffabff", rd); else passed++;
    xfer(1'b1, 2'd1, 16'h4002, 32'h1234_5678, rd, dn);
    xfer(1'b0, 2'd2, 16'h4000, 32'h0, rd, dn);
    total++; if (rd !== 32'h1234_FFFF) $display("FAIL half_upper: got %h expected 1234ffff", rd); else passed++;
    xfer(1'b1, 2'd1, 16'h4004, 32'h0000_CDEF, rd, dn);
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_CDEF) $display("FAIL half_lower: got %h expected ffffcdef", rd); else passed++;
    xfer(1'b1, 2'd0, 16'h4003, 32'h9A00_0000, rd, dn);
    xfer(1'b0, 2'd2, 16'h4000, 32'h0, rd, dn);
    total++; if (rd !== 32'h9A34_FFFF) $display("FAIL byte_lane3: got %h expected 9a34ffff", rd); else passed++;
    xfer(1'b1, 2'd2, 16'h4007, 32'h1122_3344, rd, dn);
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'h1122_3344) $display("FAIL word_misaligned: got %h expected 11223344", rd); else passed++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic dn;
    xfer(1'b1, 2'd2, 16'h0100, 32'hDEAD_BEEF, rd, dn);
    total++; if (dn !== 1'b1) $display("FAIL unmapped_wr_done: got %b expected 1", dn); else passed++;
    xfer(1'b0, 2'd2, 16'h0100, 32'h0, rd, dn);
    total++; if (dn !== 1'b1) $display("FAIL unmapped_rd_done: got %b expected 1", dn); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL unmapped_rd: got %h expected 00000000", rd); else passed++;
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'h1122_3344) $display("FAIL unmapped_no_side: got %h expected 11223344", rd); else passed++;
    xfer(1'b0, 2'd2, 16'h0000, 32'h0, rd, dn);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_msip: got %h expected 00000000", rd); else passed++;
  endtask

  task automatic test_no_ss();
    ss = 1'b0; bstart = 1'b1; ttype = 1'b1; tsize = 2'd2; addr = 16'h0000; wdata = 32'h1;
    @(negedge clk);
    bstart = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL no_ss_done: got %b expected 0", done); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL no_ss_rdata_hold: got %h expected 00000000", rdata); else passed++;
    @(negedge clk);
    total++; if (irq_sw !== 1'b0) $display("FAIL no_ss_write: got %b expected 0", irq_sw); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic dn;
    xfer(1'b1, 2'd2, 16'h0000, 32'h1, rd, dn);
    total++; if (dn !== 1'b1) $display("FAIL b2b_done0: got %b expected 1", dn); else passed++;
    xfer(1'b0, 2'd2, 16'h0000, 32'h0, rd, dn);
    total++; if (dn !== 1'b1) $display("FAIL b2b_done1: got %b expected 1", dn); else passed++;
    total++; if (rd !== 32'h1) $display("FAIL b2b_read: got %h expected 00000001", rd); else passed++;
    xfer(1'b1, 2'd2, 16'h0000, 32'h0, rd, dn);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic dn;
    ss = 1'b1; bstart = 1'b1; ttype = 1'b1; tsize = 2'd2; addr = 16'h0000; wdata = 32'h1;
    rst = 1'b1;
    @(negedge clk);
    ss = 1'b0; bstart = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else passed++;
    total++; if (irq_sw !== 1'b0) $display("FAIL rst_mid_irq_sw: got %b expected 0", irq_sw); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done_after: got %b expected 0", done); else passed++;
    total++; if (irq_sw !== 1'b0) $display("FAIL rst_mid_no_write: got %b expected 0", irq_sw); else passed++;
    xfer(1'b0, 2'd2, 16'h4004, 32'h0, rd, dn);
    total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_mid_cmp: got %h expected ffffffff", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_mtime_write();
    test_lanes();
    test_unmapped();
    test_no_ss();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv_clint.md
Name: rv_clint

Overview:
- Core-local interruptor for a single RV32 hart, slave on the D-bus behind the D-bus interconnect.
- Holds the 64-bit free-running mtime counter, a 64-bit mtimecmp and the msip bit.
- Drives the core's machine software interrupt (irq_sw) and machine timer interrupt (irq_timer).

Parameters:
- ADDR_W, 16, width of the byte-offset address seen by the block (interconnect strips the base).
- MTIME_RST, 64'h0, reset value of mtime.
- PRESCALE, 1, mtime tick divider; used only with CLINT_PRESCALE_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ss  in  1  slave select from interconnect.
- bstart  in  1  transfer start strobe, 1-cycle pulse.
- ttype  in  1  0=READ, 1=WRITE.
- tsize  in  2  0=BYTE, 1=HALFWORD, 2=WORD.
- addr  in  ADDR_W  byte offset.
- wdata  in  32  write data, lane-aligned to addr[1:0].
- rdata  out  32  read data.
- done  out  1  transfer-complete pulse.
- irq_sw  out  1  machine software interrupt.
- irq_timer  out  1  machine timer interrupt.

Behaviour:
- Register map (word offsets, addr[1:0] selects byte lanes):
  - 0x0000 msip: bit0 R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0].
  - 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0].
  - 0xBFFC mtime[63:32].
- All other offsets: reads return 0, writes ignored, done still returned.
- Reset (rst=1 at a clock edge):
  - msip=0, mtime=MTIME_RST, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - rdata=0, done=0, irq_sw=0, irq_timer=0.
- Handshake:
  - Transfer accepted at an edge where ss&&bstart.
  - done=1 exactly one cycle later, for one cycle.
  - rdata is registered and valid while done=1; rdata holds its value otherwise.
  - bstart without ss is ignored.
  - No back-pressure: a new bstart in the done cycle is accepted.
- Writes use byte-lane strobes:
  - BYTE writes lane addr[1:0].
  - HALFWORD writes lanes {addr[1],0} and {addr[1],1}.
  - WORD writes all lanes; misaligned WORD uses addr[1:0]=0.
- Reads always return the full 32-bit register regardless of tsize; the master extracts lanes.
- mtime increments by 1 every clock (64-bit, wraps FFFF..FF -> 0).
- Simultaneous write and increment on mtime:
  - Write to low word: written lanes take wdata; unwritten low lanes and the high word keep their pre-increment value (no increment or carry that cycle).
  - Write to high word: written high lanes take wdata, low word increments normally; any carry into the high word is discarded that cycle.
- Reading mtime returns the value before that edge's increment.
- irq_sw is msip[0], driven from the register (updates the cycle after the write edge).
- irq_timer is registered: each edge samples (mtime >= mtimecmp) as an unsigned 64-bit compare, using pre-edge values. Latency is one cycle after the condition becomes true. Stays asserted until mtimecmp is raised above mtime.
- Reset mid-transfer: pending done is cancelled (done=0 next cycle), no write side effect.

Optional Feature:
- Macro CLINT_PRESCALE_EN.
- Defined:
  - An internal counter counts 0..PRESCALE-1; mtime increments only on the cycle it wraps.
  - PRESCALE=1 behaves as always-increment.
  - Counter resets to 0 and also clears on any mtime write.
- Undefined: no counter; mtime increments every clock; PRESCALE is unused.

Test Plan:
- Reset then read 0xBFF8 at cycle N -> rdata≈N-1 with increasing values over successive reads; read 0x4000 -> 32'hFFFFFFFF; irq_timer=0.
- Write WORD 0x1 to 0x0000 -> irq_sw=1 the cycle after the write edge; write 0x0 -> irq_sw=0; read 0x0000 returns 0x1/0x0.
- Write mtimecmp_hi=0, mtimecmp_lo=mtime_lo+20 -> irq_timer rises exactly one cycle after mtime reaches the compare value; write mtimecmp_lo=FFFFFFFF -> irq_timer falls next cycle.
- Write mtime_lo=FFFF_FFFE, mtime_hi=0 -> after 2 ticks read mtime_hi=1, mtime_lo=0 (carry across words).
- BYTE write 0xAB to 0x4005 with mtimecmp=FFFF... -> mtimecmp_hi reads FFFF_ABFF; HALFWORD write 0x1234 to 0x4002 -> mtimecmp_lo upper half=0x1234.
- Read/write offset 0x0100 -> done pulses one cycle after bstart, rdata=0, no register changes; bstart with ss=0 -> no done.
